// File: rtl/pid_scheduler_pkg.sv
// Shared types and helpers for the time-multiplexed PID scheduler.
package pid_scheduler_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StMult, StAcc, StWrite} pid_state_e;

  typedef enum logic [1:0] {
    GselKp   = 2'd0,
    GselKi   = 2'd1,
    GselKd   = 2'd2,
    GselNone = 2'd3
  } gain_sel_e;

  localparam int unsigned AccWDefault = 24;

  // Clamp a signed controller output into the unsigned duty range 0..pwm_max.
  function automatic logic [31:0] sat_pwm(input logic signed [31:0] u, input int pwm_max);
    if (u < 0) return '0;
    if (u > pwm_max) return 32'(pwm_max);
    return u;
  endfunction

endpackage

// File: rtl/pid_scheduler_if.sv
// Command/feedback/duty bundle of the PID scheduler.
// Gain write port present only when PID_GAIN_WRITE_EN is defined.
interface pid_scheduler_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4
);
  logic              enable;
  logic [CH*N-1:0]   set_val;
  logic [CH*N-1:0]   enc;
  logic [CH*N-1:0]   pwm;
  logic [CH-1:0]     pwm_valid;
  logic              busy;
  logic              tick_miss;
`ifdef PID_GAIN_WRITE_EN
  logic              gain_we;
  logic [1:0]        gain_sel;
  logic [N-1:0]      gain_data;
`endif

  modport master (
`ifdef PID_GAIN_WRITE_EN
    output gain_we, gain_sel, gain_data,
`endif
    output enable, set_val, enc,
    input  pwm, pwm_valid, busy, tick_miss
  );

  modport slave (
`ifdef PID_GAIN_WRITE_EN
    input  gain_we, gain_sel, gain_data,
`endif
    input  enable, set_val, enc,
    output pwm, pwm_valid, busy, tick_miss
  );
endinterface

// File: rtl/pid_scheduler_tick_gen.sv
// Free-running divider: one-cycle tick every TickDiv clocks.
module pid_scheduler_tick_gen #(
  parameter int unsigned TickDiv = 75000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);
  localparam int unsigned CntW = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntW'(TickDiv - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pid_scheduler.sv
// One velocity-form PID datapath shared across CH motor channels, swept once per tick.
// Define PID_GAIN_WRITE_EN for run-time writable gains (latched per sweep).
module pid_scheduler import pid_scheduler_pkg::*; #(
  parameter int unsigned N        = 8,
  parameter int unsigned CH       = 4,
  parameter int unsigned TICK_DIV = 75000,
  parameter int unsigned ACC_W    = AccWDefault,
  parameter int          KP       = 40,
  parameter int          KI       = 8,
  parameter int          KD       = 2,
  parameter int          PWM_MAX  = 127
) (
  input logic             clk,
  input logic             rst_n,
  pid_scheduler_if.slave  bus
);
  localparam int unsigned ChW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned EW  = N + 1;

  logic tick;

  pid_scheduler_tick_gen #(.TickDiv(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(tick)
  );

  pid_state_e               state_q;
  logic [ChW-1:0]           ch_q;
  logic                     busy_q, tick_miss_q;
  logic [CH-1:0]            pwm_valid_q;
  logic [N-1:0]             pwm_q [CH];
  logic signed [EW-1:0]     e1_q  [CH];
  logic signed [EW-1:0]     e2_q  [CH];
  logic signed [ACC_W-1:0]  acc_q [CH];

  logic signed [EW-1:0]     e_q, e1_cur_q, e2_cur_q;
  logic signed [ACC_W-1:0]  acc_cur_q, p_q, i_q, d_q, u_q;
  logic signed [ACC_W-1:0]  kp_w, ki_w, kd_w;

  logic signed [N-1:0]      sv_ch, enc_ch;
  logic signed [EW-1:0]     e_new;
  logic [N-1:0]             sat;

  assign sv_ch  = bus.set_val[ch_q*N +: N];
  assign enc_ch = bus.enc[ch_q*N +: N];
  assign e_new  = {sv_ch[N-1], sv_ch} - {enc_ch[N-1], enc_ch};
  assign sat    = N'(sat_pwm(32'(u_q), PWM_MAX));

`ifdef PID_GAIN_WRITE_EN
  logic signed [N-1:0] kp_q, ki_q, kd_q, kp_sh_q, ki_sh_q, kd_sh_q;

  assign kp_w = ACC_W'(kp_sh_q);
  assign ki_w = ACC_W'(ki_sh_q);
  assign kd_w = ACC_W'(kd_sh_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_q    <= N'(KP);
      ki_q    <= N'(KI);
      kd_q    <= N'(KD);
      kp_sh_q <= N'(KP);
      ki_sh_q <= N'(KI);
      kd_sh_q <= N'(KD);
    end else begin
      if (bus.gain_we) begin
        case (bus.gain_sel)
          GselKp:  kp_q <= bus.gain_data;
          GselKi:  ki_q <= bus.gain_data;
          GselKd:  kd_q <= bus.gain_data;
          default: ;
        endcase
      end
      // Gains only change between sweeps so all channels of one sweep agree.
      if (state_q == StLoad && ch_q == '0) begin
        kp_sh_q <= kp_q;
        ki_sh_q <= ki_q;
        kd_sh_q <= kd_q;
      end
    end
  end
`else
  assign kp_w = ACC_W'(KP);
  assign ki_w = ACC_W'(KI);
  assign kd_w = ACC_W'(KD);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      busy_q      <= 1'b0;
      tick_miss_q <= 1'b0;
      pwm_valid_q <= '0;
      e_q         <= '0;
      e1_cur_q    <= '0;
      e2_cur_q    <= '0;
      acc_cur_q   <= '0;
      p_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      u_q         <= '0;
      for (int c = 0; c < CH; c++) begin
        pwm_q[c] <= '0;
        e1_q[c]  <= '0;
        e2_q[c]  <= '0;
        acc_q[c] <= '0;
      end
    end else begin
      pwm_valid_q <= '0;
      tick_miss_q <= tick && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (!bus.enable) begin
            for (int c = 0; c < CH; c++) begin
              pwm_q[c] <= '0;
              e1_q[c]  <= '0;
              e2_q[c]  <= '0;
              acc_q[c] <= '0;
            end
          end else if (tick) begin
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          e_q       <= e_new;
          e1_cur_q  <= e1_q[ch_q];
          e2_cur_q  <= e2_q[ch_q];
          acc_cur_q <= acc_q[ch_q];
          state_q   <= StMult;
        end
        StMult: begin
          p_q     <= kp_w * (ACC_W'(e_q) - ACC_W'(e1_cur_q));
          i_q     <= ki_w * ACC_W'(e_q);
          d_q     <= kd_w * (ACC_W'(e_q) - (ACC_W'(e1_cur_q) <<< 1) + ACC_W'(e2_cur_q));
          state_q <= StAcc;
        end
        StAcc: begin
          u_q     <= acc_cur_q + p_q + i_q + d_q;
          state_q <= StWrite;
        end
        StWrite: begin
          pwm_q[ch_q]       <= sat;
          pwm_valid_q[ch_q] <= 1'b1;
          acc_q[ch_q]       <= ACC_W'(sat);  // clamped value stored: anti-windup
          e2_q[ch_q]        <= e1_cur_q;
          e1_q[ch_q]        <= e_q;
          if (ch_q == ChW'(CH - 1)) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= StLoad;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_pwm
    assign bus.pwm[g*N +: N] = pwm_q[g];
  end

  assign bus.pwm_valid = pwm_valid_q;
  assign bus.busy      = busy_q;
  assign bus.tick_miss = tick_miss_q;
endmodule
